tdc_hw_accum: RTL and testbench



---
 rtl/tdc_pkg.sv | 32 +++
 rtl/tdc_minmax_trk.sv | 40 ++++
 rtl/tdc_hw_accum.sv | 100 ++++++++++
 tb/tb_tdc_hw_accum.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Brief    : Shared types and sizing helpers for the TDC Hamming-weight accumulator.
// Revision : 1.0
// ============================================================================
package tdc_pkg;

  typedef enum logic [1:0] {
    ACCUM_IDLE = 2'd0,
    ACCUM_RUN  = 2'd1,
    ACCUM_DONE = 2'd2
  } accum_state_t;

  localparam int unsigned c_N_DEFAULT            = 64;
  localparam int unsigned c_LOG2_SAMPLES_DEFAULT = 4;

  function automatic int unsigned hw_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned n, input int unsigned log2_samples);
    return $clog2(n) + 1 + log2_samples;
  endfunction

  // Out-of-range weights cannot come from a healthy core; saturate rather than wrap.
  function automatic int unsigned clamp_hw(input int unsigned hw, input int unsigned n);
    return (hw > n) ? n : hw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_minmax_trk.sv
`default_nettype none
// ============================================================================
// Module   : tdc_minmax_trk
// Brief    : Registered batch minimum/maximum tracker with synchronous clear.
// Revision : 1.0
// ============================================================================
module tdc_minmax_trk #(
  parameter int unsigned W       = 7,
  parameter int unsigned MAX_VAL = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         update,
  input  logic [W-1:0] hw,
  output logic [W-1:0] hw_min,
  output logic [W-1:0] hw_max
);

  logic [W-1:0] r_min;
  logic [W-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= W'(MAX_VAL);
      r_max <= '0;
    end else if (clear) begin
      r_min <= W'(MAX_VAL);
      r_max <= '0;
    end else if (update) begin
      if (hw < r_min) r_min <= hw;
      if (hw > r_max) r_max <= hw;
    end
  end

  assign hw_min = r_min;
  assign hw_max = r_max;

endmodule
`default_nettype wire

// File: rtl/tdc_hw_accum.sv
`default_nettype none
// ============================================================================
// Module   : tdc_hw_accum
// Brief    : Accumulates a power-of-two batch of TDC Hamming weights into
//            sum/mean and, with TDC_HW_ACCUM_MINMAX_EN defined, min/max.
// Revision : 1.0
// ============================================================================
module tdc_hw_accum
  import tdc_pkg::*;
#(
  parameter int unsigned N            = c_N_DEFAULT,
  parameter int unsigned LOG2_SAMPLES = c_LOG2_SAMPLES_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  start,
  input  logic [hw_width(N)-1:0]                hw_in,
  input  logic                                  hw_valid,
  output logic                                  busy,
  output logic                                  done,
  output logic [sum_width(N, LOG2_SAMPLES)-1:0] sum,
  output logic [hw_width(N)-1:0]                mean,
  output logic [hw_width(N)-1:0]                hw_min,
  output logic [hw_width(N)-1:0]                hw_max
);

  localparam int unsigned HW_W  = hw_width(N);
  localparam int unsigned SUM_W = sum_width(N, LOG2_SAMPLES);

  accum_state_t            r_state;
  accum_state_t            w_state_nxt;
  logic [LOG2_SAMPLES-1:0] r_count;
  logic [SUM_W-1:0]        r_sum;
  logic [HW_W-1:0]         w_hw_clamp;
  logic                    w_clear;
  logic                    w_accept;

  assign w_hw_clamp = HW_W'(clamp_hw(32'(hw_in), N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM_IDLE;
    else        r_state <= w_state_nxt;
  end

  // start outranks hw_valid; en low masks both strobes and freezes the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    if (en) begin
      if (start) begin
        w_clear     = 1'b1;
        w_state_nxt = ACCUM_RUN;
      end else if (r_state == ACCUM_RUN && hw_valid) begin
        w_accept = 1'b1;
        if (r_count == '1) w_state_nxt = ACCUM_DONE;
      end
    end
  end

  // The count rolls from all-ones to zero exactly on the DONE transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sum   <= r_sum + SUM_W'(w_hw_clamp);
      r_count <= r_count + 1'b1;
    end
  end

  assign busy = (r_state == ACCUM_RUN);
  assign done = (r_state == ACCUM_DONE);
  assign sum  = r_sum;
  assign mean = r_sum[SUM_W-1:LOG2_SAMPLES];

`ifdef TDC_HW_ACCUM_MINMAX_EN
  tdc_minmax_trk #(
    .W       (HW_W),
    .MAX_VAL (N)
  ) u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_clear),
    .update (w_accept),
    .hw     (w_hw_clamp),
    .hw_min (hw_min),
    .hw_max (hw_max)
  );
`else
  assign hw_min = '0;
  assign hw_max = HW_W'(N);
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdc_hw_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_hw_accum
// Brief    : Self-checking bench for tdc_hw_accum against a sample-queue model.
// Revision : 1.0
// ============================================================================
module tb_tdc_hw_accum;

  localparam int N     = 64;
  localparam int BATCH = 16;
  localparam int HW_W  = 7;
  localparam int SUM_W = 11;
  localparam int VEC_W = 2 + SUM_W + 3 * HW_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             hw_valid = 1'b0;
  logic [HW_W-1:0]  hw_in = '0;
  logic             busy, done;
  logic [SUM_W-1:0] sum;
  logic [HW_W-1:0]  mean, hw_min, hw_max;
  logic [VEC_W-1:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the accepted (clamped) samples of the current batch.
  int q[$];
  bit m_run  = 1'b0;
  bit m_done = 1'b0;

  tdc_hw_accum #(.N(N), .LOG2_SAMPLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .hw_in    (hw_in),
    .hw_valid (hw_valid),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .mean     (mean),
    .hw_min   (hw_min),
    .hw_max   (hw_max)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, sum, mean, hw_min, hw_max};

  function automatic int clampv(input int v);
    return (v > N) ? N : v;
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    int s = 0;
    int mn = N;
    int mx = 0;
    foreach (q[i]) begin
      s += q[i];
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
`ifndef TDC_HW_ACCUM_MINMAX_EN
    mn = 0;
    mx = N;
`endif
    return {m_run, m_done, SUM_W'(s), HW_W'(s / BATCH), HW_W'(mn), HW_W'(mx)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
  endtask

  // Drive one cycle, advance the model, and return 1 time unit after the edge.
  task automatic step(input bit e, input bit s, input bit v, input int h);
    en = e; start = s; hw_valid = v; hw_in = HW_W'(h);
    @(posedge clk);
    if (e) begin
      if (s) begin
        q.delete(); m_run = 1'b1; m_done = 1'b0;
      end else if (m_run && v) begin
        q.push_back(clampv(h));
        if (q.size() == BATCH) begin m_run = 1'b0; m_done = 1'b1; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_values: got %h exp %h", obs, exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 40);
    n_tests++;
    if (obs !== exp_vec() || sum !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid_ignored: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_const();
    step(1, 1, 0, 0);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL start_busy: got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    for (int i = 0; i < BATCH; i++) begin
      step(1, 0, 1, 32);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL const_cycle%0d: got %h exp %h", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (sum !== 512 || mean !== 32 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL const_result: got sum=%0d mean=%0d done=%b exp 512 32 1", sum, mean, done);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 1, $urandom_range(0, 64));
    n_tests++;
    if (obs !== exp_vec() || sum !== 512) begin
      n_fail++; $display("FAIL done_hold: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_ramp_gaps();
    step(1, 1, 0, 0);
    for (int i = 0; i < BATCH; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step(1, 0, 0, $urandom_range(0, 64));
        n_tests++;
        if (obs !== exp_vec()) begin
          n_fail++; $display("FAIL ramp_gap%0d: got %h exp %h", i, obs, exp_vec());
        end
      end
      step(1, 0, 1, i);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL ramp_sample%0d: got %h exp %h", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (sum !== 120 || mean !== 7 || done !== 1'b1) begin
      n_fail++; $display("FAIL ramp_result: got sum=%0d mean=%0d exp 120 7", sum, mean);
    end
  endtask

  task automatic test_start_priority();
    step(1, 1, 1, 50);
    for (int i = 0; i < BATCH; i++) step(1, 0, 1, 10);
    n_tests++;
    if (obs !== exp_vec() || sum !== 160) begin
      n_fail++; $display("FAIL start_priority: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 20);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs !== exp_vec() || busy !== 1'b0 || sum !== 0) begin
      n_fail++; $display("FAIL async_reset: got %h exp %h", obs, exp_vec());
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 1, 0, 0);
    for (int i = 0; i < BATCH; i++) step(1, 0, 1, 5);
    n_tests++;
    if (obs !== exp_vec() || sum !== 80) begin
      n_fail++; $display("FAIL after_reset_batch: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_enable_freeze();
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom_range(0, 64));
    for (int i = 0; i < 4; i++) begin
      step(0, (i == 2), 1, $urandom_range(0, 64));
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL en_freeze%0d: got %h exp %h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 11; i++) step(1, 0, 1, $urandom_range(0, 64));
    n_tests++;
    if (obs !== exp_vec() || done !== 1'b1) begin
      n_fail++; $display("FAIL en_resume: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_clamp();
    step(1, 1, 0, 0);
    for (int i = 0; i < BATCH; i++) step(1, 0, 1, (i == 7) ? 70 : $urandom_range(0, 60));
    n_tests++;
    if (obs !== exp_vec() || hw_max !== 7'd64) begin
      n_fail++; $display("FAIL clamp: got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1), $urandom_range(0, 80));
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d: got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ramp_gaps();
    test_start_priority();
    test_async_reset();
    test_enable_freeze();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
